// File: rtl/adder_serial_accum_if.sv
// Operand/result handshake bundle for adder_serial_accum.
// slave = the adder itself, master = the operand source / result consumer.
interface adder_serial_accum_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_mode;
  logic             acc_clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_mode, acc_clear, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_mode, acc_clear, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/adder_serial_accum.sv
// Bit-serial (CHUNK bits per clock) adder with optional accumulate mode and
// valid/ready handshakes on the operand and result sides.
//
// state  | meaning
// S_IDLE | in_ready high, waiting for an operand beat (acc_clear honoured here)
// S_RUN  | one chunk added per cycle; final cycle commits result to outputs
// S_DONE | out_valid high, outputs held until out_ready
module adder_serial_accum #(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = WIDTH / CHUNK
) (
  input logic                   clk,
  input logic                   rst_n,
  adder_serial_accum_if.slave   io_bus
);

  localparam int CW = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_last;
  logic [WIDTH-1:0] w_opa_sel;
  logic [CHUNK:0]   w_csum;
  logic [WIDTH-1:0] w_chunk_hi;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_ovf;

  // Clear beats accumulate: an accepted mode=1 beat with acc_clear sees ACC=0.
  assign w_opa_sel  = io_bus.in_mode ? (io_bus.acc_clear ? '0 : r_acc) : io_bus.in_a;
  assign w_last     = (r_cnt == CW'(NCHUNK));
  assign w_csum     = {1'b0, r_opa[CHUNK-1:0]} + {1'b0, r_opb[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, r_carry};
  assign w_chunk_hi = WIDTH'(w_csum[CHUNK-1:0]) << (WIDTH - CHUNK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (io_bus.in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (io_bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operands shift right one chunk per cycle while the result fills in from
  // the top; the extra cycle at r_cnt == NCHUNK commits it to the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa      <= '0;
      r_opb      <= '0;
      r_res      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_out_sum  <= '0;
      r_out_cout <= 1'b0;
      r_out_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.acc_clear) r_acc <= '0;
          if (io_bus.in_valid) begin
            r_opa   <= w_opa_sel;
            r_opb   <= io_bus.in_b;
            r_carry <= io_bus.in_cin;
            r_cnt   <= '0;
            r_a_msb <= w_opa_sel[WIDTH-1];
            r_b_msb <= io_bus.in_b[WIDTH-1];
          end
        end
        S_RUN: begin
          if (!w_last) begin
            r_opa   <= r_opa >> CHUNK;
            r_opb   <= r_opb >> CHUNK;
            r_res   <= (r_res >> CHUNK) | w_chunk_hi;
            r_carry <= w_csum[CHUNK];
            r_cnt   <= r_cnt + CW'(1);
          end else begin
            r_out_sum  <= r_res;
            r_out_cout <= r_carry;
            r_out_ovf  <= (r_a_msb == r_b_msb) && (r_res[WIDTH-1] != r_a_msb);
          end
        end
        S_DONE: begin
          if (io_bus.out_ready) r_acc <= r_out_sum;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.out_sum   = r_out_sum;
  assign io_bus.out_cout  = r_out_cout;
  assign io_bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_adder_serial_accum.sv
// Self-checking bench for adder_serial_accum: directed vectors plus random
// operations compared against an arithmetic reference model.
module tb_adder_serial_accum;
  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_serial_accum_if #(.WIDTH(W)) bus ();

  adder_serial_accum #(.WIDTH(W), .CHUNK(C)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_acc = '0;

  // Reference: plain integer arithmetic on the chosen operands.
  task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic mode, input logic clr,
                          output logic [W-1:0] s, output logic co, output logic ov);
    logic [W-1:0] opa;
    longint full, sfull, smax, smin;
    opa   = mode ? (clr ? '0 : m_acc) : a;
    full  = longint'(opa) + longint'(b) + longint'(cin);
    s     = full[W-1:0];
    co    = (full >> W) != 0;
    sfull = longint'($signed(opa)) + longint'($signed(b)) + longint'(cin);
    smax  = (longint'(1) <<< (W-1)) - 1;
    smin  = -(longint'(1) <<< (W-1));
    ov    = (sfull > smax) || (sfull < smin);
  endtask

  // Drives one beat, measures latency, holds out_ready low for 'hold' cycles
  // (while offering junk beats and acc_clear), then completes the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic mode, input logic clr,
                        input int hold,
                        output logic [W-1:0] s, output logic co, output logic ov,
                        output int lat, output bit stable, output bit tmo);
    int wc;
    wc = 0; tmo = 0; stable = 1; lat = 0; s = '0; co = 0; ov = 0;
    while (bus.in_ready !== 1'b1 && wc < 50) begin
      @(posedge clk); #1; wc++;
    end
    if (bus.in_ready !== 1'b1) begin tmo = 1; return; end
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_mode = mode;
    bus.acc_clear = clr; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.acc_clear = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (bus.out_valid !== 1'b1) begin tmo = 1; return; end
    s = bus.out_sum; co = bus.out_cout; ov = bus.out_ovf;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.in_a = W'($urandom); bus.in_b = W'($urandom);
      bus.in_mode = 1'b1; bus.acc_clear = 1'b1;
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== s || bus.out_cout !== co ||
          bus.out_ovf !== ov || bus.in_ready !== 1'b0) stable = 0;
    end
    bus.in_valid = 1'b0; bus.acc_clear = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) stable = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf} !==
        {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b sum=%h co=%b ov=%b want 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
    end
    #11 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [6] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0FFF, 16'h00FF, 16'h8000};
    logic [W-1:0] tb [6] = '{16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h8000};
    logic         tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] es, os; logic ec, eo, oc, oo; int lat; bit st, tmo;
    for (int i = 0; i < 6; i++) begin
      model_op(ta[i], tb[i], tc[i], 1'b0, 1'b0, es, ec, eo);
      run_op(ta[i], tb[i], tc[i], 1'b0, 1'b0, 0, os, oc, oo, lat, st, tmo);
      checks++;
      if (tmo || {os, oc, oo} !== {es, ec, eo}) begin
        errors++;
        $display("FAIL basic_result[%0d] got sum=%h co=%b ov=%b tmo=%0d want sum=%h co=%b ov=%b",
                 i, os, oc, oo, tmo, es, ec, eo);
      end
      checks++;
      if (lat != N + 1) begin
        errors++;
        $display("FAIL basic_latency[%0d] got %0d want %0d", i, lat, N + 1);
      end
      m_acc = es;
    end
  endtask

  task automatic test_accum();
    int exp_tab [4] = '{100, 101, 102, 5};
    logic [W-1:0] bt [4] = '{16'd100, 16'd1, 16'd1, 16'd5};
    logic         ct [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] os; logic oc, oo; int lat; bit st, tmo;
    bus.acc_clear = 1'b1;
    @(posedge clk); #1;
    bus.acc_clear = 1'b0;
    m_acc = '0;
    for (int i = 0; i < 4; i++) begin
      run_op(16'hBEEF, bt[i], 1'b0, 1'b1, ct[i], 0, os, oc, oo, lat, st, tmo);
      checks++;
      if (tmo || os !== W'(exp_tab[i])) begin
        errors++;
        $display("FAIL accum_sum[%0d] got %0d tmo=%0d want %0d", i, os, tmo, exp_tab[i]);
      end
      m_acc = os;
    end
    m_acc = W'(exp_tab[3]);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] es, os; logic ec, eo, oc, oo; int lat; bit st, tmo;
    model_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, es, ec, eo);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 3, os, oc, oo, lat, st, tmo);
    checks++;
    if (tmo || !st) begin
      errors++;
      $display("FAIL backpressure_hold got stable=%0d tmo=%0d want stable=1 tmo=0", st, tmo);
    end
    checks++;
    if (os !== es) begin
      errors++;
      $display("FAIL backpressure_sum got %h want %h", os, es);
    end
    m_acc = es;
    model_op(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, es, ec, eo);
    run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 0, os, oc, oo, lat, st, tmo);
    checks++;
    if (tmo || os !== es) begin
      errors++;
      $display("FAIL backpressure_acc got %h tmo=%0d want %h", os, tmo, es);
    end
    m_acc = es;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, es, os; logic cin, mode, clr, ec, eo, oc, oo;
    logic [W-1:0] edge_vals [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    int lat, hold; bit st, tmo;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      cin  = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 3) == 0);
      hold = $urandom_range(0, 3);
      model_op(a, b, cin, mode, clr, es, ec, eo);
      run_op(a, b, cin, mode, clr, hold, os, oc, oo, lat, st, tmo);
      checks++;
      if (tmo || {os, oc, oo} !== {es, ec, eo} || lat != N + 1 || !st) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b mode=%b clr=%b got sum=%h co=%b ov=%b lat=%0d stable=%0d tmo=%0d want sum=%h co=%b ov=%b lat=%0d stable=1",
                 i, a, b, cin, mode, clr, os, oc, oo, lat, st, tmo, es, ec, eo, N + 1);
      end
      m_acc = es;
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] es, os; logic ec, eo, oc, oo; int lat; bit st, tmo, seen;
    run_op(16'h8101, 16'h8202, 1'b0, 1'b0, 1'b0, 0, os, oc, oo, lat, st, tmo);
    bus.in_a = 16'h1234; bus.in_b = 16'h4321; bus.in_cin = 1'b1; bus.in_mode = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf} !==
        {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset got rdy=%b vld=%b sum=%h co=%b ov=%b want 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    m_acc = '0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrun_no_partial got out_valid=1 want 0");
    end
    model_op(16'h0000, 16'd4, 1'b0, 1'b1, 1'b0, es, ec, eo);
    run_op(16'hAAAA, 16'd4, 1'b0, 1'b1, 1'b0, 0, os, oc, oo, lat, st, tmo);
    checks++;
    if (tmo || os !== es) begin
      errors++;
      $display("FAIL midrun_acc_zero got %h tmo=%0d want %h", os, tmo, es);
    end
    m_acc = es;
    model_op(16'd3, 16'd4, 1'b0, 1'b0, 1'b0, es, ec, eo);
    run_op(16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 0, os, oc, oo, lat, st, tmo);
    checks++;
    if (tmo || {os, oc, oo} !== {es, ec, eo}) begin
      errors++;
      $display("FAIL midrun_next_add got %h tmo=%0d want %h", os, tmo, es);
    end
    m_acc = es;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.in_mode = 1'b0; bus.acc_clear = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_accum();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
